stack_unit: RTL
===============

Name: stack_unit

Overview:
- Hardware LIFO stack. It is the responder for the Push/Pop interface that the pipelined datapath drives from its MEMORY stage.
- The datapath supplies PushM, PopM and WriteData (the store data of the MEM stage).
- The stack returns StackReadData combinationally, in the same cycle. The datapath's MemSrc mux captures it into the MEM/WB register at the next edge.
- Status flags (full, empty, sticky error) go to the top level for debug and testbench checking.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 16, number of stack entries; must be a power of two, at least 2.
- ADDR_W, 4, log2(DEPTH); the index width.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  synchronous active-high reset.
- PushM  input  1  push request in the MEM stage.
- PopM  input  1  pop request in the MEM stage.
- WriteData  input  WIDTH  data to push.
- ErrClr  input  1  clears the sticky Overflow and Underflow flags.
- StackReadData  output  WIDTH  current top-of-stack value (combinational).
- Count  output  ADDR_W+1  number of valid entries, 0 to DEPTH.
- Full  output  1  high when Count == DEPTH.
- Empty  output  1  high when Count == 0.
- Overflow  output  1  sticky: a push was attempted while full.
- Underflow  output  1  sticky: a pop was attempted while empty.

Behaviour:
- State:
  - mem[DEPTH] storage array.
  - top: ADDR_W bits, index of the next free slot.
  - Count register.
  - Overflow and Underflow flag registers.
- Reset (RST=1 at an edge): top=0, Count=0, Overflow=0, Underflow=0. mem is not cleared.
  - Outputs after reset: StackReadData=0, Empty=1, Full=0.
  - RST overrides any PushM, PopM or ErrClr in the same cycle, so a reset mid-sequence discards the stack contents.
- Read path:
  - StackReadData = mem[top-1] (modulo DEPTH) when Count != 0; otherwise 0.
  - Zero latency: valid in the same cycle as PopM.
- Push only (PushM=1, PopM=0):
  - Not Full: mem[top] <= WriteData; top <= top+1; Count <= Count+1.
  - Full: the push is dropped (mem, top and Count unchanged) and Overflow <= 1. See the Optional Feature for the STACK_WRAP_EN variant.
- Pop only (PopM=1, PushM=0):
  - Not Empty: StackReadData shows the old top this cycle; top <= top-1; Count <= Count-1.
  - Empty: StackReadData = 0; no state change; Underflow <= 1.
- Push and pop together:
  - Not Empty: replace the top entry. StackReadData shows the old top; mem[top-1] <= WriteData; top and Count unchanged. Neither flag is set, even when Full.
  - Empty: Underflow <= 1, and the push still proceeds (mem[0] <= WriteData, Count=1).
- Neither request: all state holds.
- Pointer arithmetic:
  - top wraps modulo DEPTH (natural ADDR_W-bit overflow).
  - Count saturates within 0 to DEPTH by construction; it never wraps.
- Flags:
  - Full and Empty are decoded from Count; no separate registers.
  - Overflow and Underflow stay set until ErrClr=1 or RST, clearing at the next edge.
  - If an error condition occurs in the same cycle as ErrClr, set wins and the flag reads 1 after the edge.
- No X on outputs at any time after the first reset edge.

Optional Feature:
- Macro: STACK_WRAP_EN.
- Defined (circular stack): a push while Full and not popping overwrites the oldest entry.
  - mem[top] <= WriteData; top <= top+1 (wraps); Count stays DEPTH.
  - Overflow <= 1 still.
  - The next DEPTH pops return the newest DEPTH values in LIFO order.
- Undefined: a push while Full is dropped exactly as described in Behaviour.
- All other behaviour is identical in both builds.

Test Plan:
- Reset then idle -> Count=0, Empty=1, Full=0, StackReadData=0, Overflow=0, Underflow=0.
- Push 0x11, 0x22, 0x33 on consecutive cycles, then pop 3 times -> StackReadData=0x33, 0x22, 0x11 in the pop cycles; Count goes 3, 2, 1, 0; Empty=1 at the end.
- Push while Full and pop while Empty:
  - Push 1 to 16 (DEPTH=16) -> Full=1.
  - Push 0xAA -> Overflow=1, Count=16, top entry still 16 (with STACK_WRAP_EN: top entry 0xAA; popping 16 times yields 0xAA, 16, 15, ..., 2).
  - Pop on an empty stack -> Underflow=1, StackReadData=0.
- Simultaneous push and pop:
  - Stack holding 0x5, 0x7: PushM=PopM=1 with WriteData=0x9 -> StackReadData=0x7 that cycle; Count stays 2; the next pop returns 0x9.
  - On an empty stack with WriteData=0x4 -> Underflow=1, Count=1, top entry 0x4.
- Error clearing: Overflow=1; ErrClr=1 for one cycle -> Overflow=0. Then ErrClr=1 together with a push while Full -> Overflow stays 1.
- Reset mid-operation: after 5 pushes, assert RST together with PushM=1 -> Count=0, Empty=1, StackReadData=0; a following pop sets Underflow=1.

Source files
------------

// File: rtl/stack_unit.sv
// stack_unit: hardware LIFO stack answering the MEM-stage Push/Pop interface.
// The top-of-stack value is returned combinationally in the request cycle.
// Full/Empty are decoded from the entry count. Overflow/Underflow are sticky
// until ErrClr or RST.
// Optional build macro STACK_WRAP_EN: a push while full overwrites the oldest
// entry (circular stack) instead of being dropped.
module stack_unit #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              PushM,
  input  logic              PopM,
  input  logic [WIDTH-1:0]  WriteData,
  input  logic              ErrClr,
  output logic [WIDTH-1:0]  StackReadData,
  output logic [ADDR_W:0]   Count,
  output logic              Full,
  output logic              Empty,
  output logic              Overflow,
  output logic              Underflow
);

  localparam logic [ADDR_W-1:0] ONE_A   = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   ONE_C   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   ZERO_C  = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] top;
  logic [ADDR_W-1:0] top_m1;
  logic [ADDR_W-1:0] top_nxt;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   count_nxt;
  logic              wr_en;
  logic              ovf;
  logic              udf;
  logic              ovf_set;
  logic              udf_set;
  logic              is_full;
  logic              is_empty;

  assign is_full  = (count == DEPTH_C);
  assign is_empty = (count == ZERO_C);

  // Decode the request into a storage write, pointer/count update and error events.
  always_comb begin
    top_m1    = top - ONE_A;
    wr_en     = 1'b0;
    wr_addr   = top;
    top_nxt   = top;
    count_nxt = count;
    ovf_set   = 1'b0;
    udf_set   = 1'b0;
    case ({PushM, PopM})
      2'b10: begin
        if (!is_full) begin
          wr_en     = 1'b1;
          top_nxt   = top + ONE_A;
          count_nxt = count + ONE_C;
        end else begin
`ifdef STACK_WRAP_EN
          // Circular mode: overwrite the oldest slot, count stays at DEPTH.
          wr_en   = 1'b1;
          top_nxt = top + ONE_A;
`endif
          ovf_set = 1'b1;
        end
      end
      2'b01: begin
        if (!is_empty) begin
          top_nxt   = top_m1;
          count_nxt = count - ONE_C;
        end else begin
          udf_set = 1'b1;
        end
      end
      2'b11: begin
        if (!is_empty) begin
          // Replace the top entry: pointer and count do not move.
          wr_en   = 1'b1;
          wr_addr = top_m1;
        end else begin
          // Pop side underflows but the push side still lands.
          udf_set   = 1'b1;
          wr_en     = 1'b1;
          top_nxt   = top + ONE_A;
          count_nxt = ONE_C;
        end
      end
      default: begin
        wr_en = 1'b0;
      end
    endcase
  end

  // Storage write; contents are not cleared by reset, but a reset cycle blocks writes.
  always_ff @(posedge CLK) begin
    if (!RST && wr_en) begin
      mem[wr_addr] <= WriteData;
    end
  end

  // Pointer, count and sticky flag registers; a new error event beats ErrClr.
  always_ff @(posedge CLK) begin
    if (RST) begin
      top   <= {ADDR_W{1'b0}};
      count <= ZERO_C;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      top   <= top_nxt;
      count <= count_nxt;
      ovf   <= ovf_set | (ovf & ~ErrClr);
      udf   <= udf_set | (udf & ~ErrClr);
    end
  end

  assign StackReadData = is_empty ? {WIDTH{1'b0}} : mem[top_m1];
  assign Count         = count;
  assign Full          = is_full;
  assign Empty         = is_empty;
  assign Overflow      = ovf;
  assign Underflow     = udf;

endmodule
